// File: rtl/mac_pkg.sv
// Shared types, lane limits and width helper for the multi-lane MAC accumulator.
package mac_pkg;

   typedef enum logic {
      MAC_UNSIGNED = 1'b0,
      MAC_SIGNED   = 1'b1
   } mac_mode_t;

   localparam int LANES_MIN = 1;
   localparam int LANES_MAX = 4;

   // Width that holds the sum of all lane products without loss.
   function automatic int sum_width(input int input_width, input int lanes);
      return 2 * input_width + $clog2(lanes);
   endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One multiplier lane: full-width product of two operands, registered.
module mac_lane_mult
   import mac_pkg::*;
#(
   parameter int INPUT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [INPUT_WIDTH-1:0]     a,
   input  logic [INPUT_WIDTH-1:0]     b,
   input  logic                       signed_mode,
   output logic [2*INPUT_WIDTH-1:0]   product
);

   localparam int PW = 2 * INPUT_WIDTH;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] product_next;
   logic [PW-1:0] product_reg;

   // Low PW bits of the extended product are correct for both signednesses.
   always_comb begin
      a_ext        = {{INPUT_WIDTH{signed_mode & a[INPUT_WIDTH-1]}}, a};
      b_ext        = {{INPUT_WIDTH{signed_mode & b[INPUT_WIDTH-1]}}, b};
      product_next = a_ext * b_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_reg <= '0;
      end else begin
         product_reg <= product_next;
      end
   end

   assign product = product_reg;

endmodule

// File: rtl/mac_accum.sv
// Four-stage streaming multiply-accumulate over framed beats of LANES operand pairs,
// with per-frame signed/unsigned and saturate/wrap selection.
module mac_accum
   import mac_pkg::*;
#(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 40,
   parameter int LANES        = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [LANES*INPUT_WIDTH-1:0]  in_a,
   input  logic [LANES*INPUT_WIDTH-1:0]  in_b,
   input  logic                          in_first,
   input  logic                          in_last,
   input  logic                          signed_mode,
   input  logic                          sat_en,
   output logic [OUTPUT_WIDTH-1:0]       out_val,
   output logic                          out_valid,
   output logic                          out_overflow,
   output logic                          busy
);

   localparam int PW = 2 * INPUT_WIDTH;
   localparam int SW = sum_width(INPUT_WIDTH, LANES);
   localparam int AW = LANES * INPUT_WIDTH;
   localparam int OW = OUTPUT_WIDTH;

   if (OUTPUT_WIDTH < SW) begin : g_width_check
      $error("mac_accum: OUTPUT_WIDTH is narrower than the lane sum");
   end
   if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_lane_check
      $error("mac_accum: LANES out of range");
   end

   // Frame tracking and S1 input registers
   logic      frame_open_reg, frame_sat_reg;
   mac_mode_t frame_mode_reg;
   logic      beat_first, beat_sat;
   mac_mode_t beat_mode;
   logic      s1_valid_reg, s1_first_reg, s1_last_reg, s1_sat_reg;
   mac_mode_t s1_mode_reg;
   logic [AW-1:0] s1_a_reg, s1_b_reg;

   // A beat with no open frame always starts one; mode is latched on that beat.
   always_comb begin
      beat_first = in_first | ~frame_open_reg;
      beat_mode  = beat_first ? mac_mode_t'(signed_mode) : frame_mode_reg;
      beat_sat   = beat_first ? sat_en : frame_sat_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_open_reg <= 1'b0;
         frame_mode_reg <= MAC_UNSIGNED;
         frame_sat_reg  <= 1'b0;
         s1_valid_reg   <= 1'b0;
         s1_first_reg   <= 1'b0;
         s1_last_reg    <= 1'b0;
         s1_mode_reg    <= MAC_UNSIGNED;
         s1_sat_reg     <= 1'b0;
         s1_a_reg       <= '0;
         s1_b_reg       <= '0;
      end else begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            frame_open_reg <= ~in_last;
            frame_mode_reg <= beat_mode;
            frame_sat_reg  <= beat_sat;
            s1_first_reg   <= beat_first;
            s1_last_reg    <= in_last;
            s1_mode_reg    <= beat_mode;
            s1_sat_reg     <= beat_sat;
            s1_a_reg       <= in_a;
            s1_b_reg       <= in_b;
         end
      end
   end

   // S2: per-lane products
   logic [PW-1:0] products [LANES];
   logic      s2_valid_reg, s2_first_reg, s2_last_reg, s2_sat_reg;
   mac_mode_t s2_mode_reg;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane_mult #(
         .INPUT_WIDTH (INPUT_WIDTH)
      ) u_mult (
         .clk         (clk),
         .rst_n       (rst_n),
         .a           (s1_a_reg[gi*INPUT_WIDTH +: INPUT_WIDTH]),
         .b           (s1_b_reg[gi*INPUT_WIDTH +: INPUT_WIDTH]),
         .signed_mode (s1_mode_reg == MAC_SIGNED),
         .product     (products[gi])
      );
   end

   // S3: lane sum, extended to the accumulator width
   logic [SW-1:0] lane_sum;
   logic [OW-1:0] sum_ext;
   logic [OW-1:0] s3_sum_reg;
   logic      s3_valid_reg, s3_first_reg, s3_last_reg, s3_sat_reg;
   mac_mode_t s3_mode_reg;

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sum = lane_sum + (SW'(products[k]) |
                    ((s2_mode_reg == MAC_SIGNED && products[k][PW-1]) ? ~SW'({PW{1'b1}}) : '0));
      end
      sum_ext = OW'(lane_sum) |
                ((s2_mode_reg == MAC_SIGNED && lane_sum[SW-1]) ? ~OW'({SW{1'b1}}) : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_first_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s2_mode_reg  <= MAC_UNSIGNED;
         s2_sat_reg   <= 1'b0;
         s3_valid_reg <= 1'b0;
         s3_first_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
         s3_mode_reg  <= MAC_UNSIGNED;
         s3_sat_reg   <= 1'b0;
         s3_sum_reg   <= '0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         s2_first_reg <= s1_first_reg;
         s2_last_reg  <= s1_last_reg;
         s2_mode_reg  <= s1_mode_reg;
         s2_sat_reg   <= s1_sat_reg;
         s3_valid_reg <= s2_valid_reg;
         s3_first_reg <= s2_first_reg;
         s3_last_reg  <= s2_last_reg;
         s3_mode_reg  <= s2_mode_reg;
         s3_sat_reg   <= s2_sat_reg;
         s3_sum_reg   <= sum_ext;
      end
   end

   // S4: accumulate with overflow detection, then the result register
   logic [OW-1:0] acc_reg, acc_next;
   logic          ovf_reg, ovf_next;
   logic [OW:0]   add_full;
   logic          add_ovf;
   logic          s4_valid_reg, s4_last_reg;
   logic [OW-1:0] out_val_reg;
   logic          out_valid_reg, out_overflow_reg;

   always_comb begin
      add_full = {1'b0, acc_reg} + {1'b0, s3_sum_reg};
      if (s3_mode_reg == MAC_SIGNED) begin
         add_ovf = (acc_reg[OW-1] == s3_sum_reg[OW-1]) && (add_full[OW-1] != acc_reg[OW-1]);
      end else begin
         add_ovf = add_full[OW];
      end
      acc_next = acc_reg;
      ovf_next = ovf_reg;
      if (s3_valid_reg) begin
         if (s3_first_reg) begin
            acc_next = s3_sum_reg;
            ovf_next = 1'b0;
         end else begin
            ovf_next = ovf_reg | add_ovf;
            if (add_ovf && s3_sat_reg) begin
               if (s3_mode_reg == MAC_SIGNED) begin
                  acc_next = acc_reg[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
               end else begin
                  acc_next = '1;
               end
            end else begin
               acc_next = add_full[OW-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg          <= '0;
         ovf_reg          <= 1'b0;
         s4_valid_reg     <= 1'b0;
         s4_last_reg      <= 1'b0;
         out_val_reg      <= '0;
         out_valid_reg    <= 1'b0;
         out_overflow_reg <= 1'b0;
      end else begin
         acc_reg       <= acc_next;
         ovf_reg       <= ovf_next;
         s4_valid_reg  <= s3_valid_reg;
         s4_last_reg   <= s3_valid_reg & s3_last_reg;
         out_valid_reg <= s4_valid_reg & s4_last_reg;
         if (s4_valid_reg && s4_last_reg) begin
            out_val_reg      <= acc_reg;
            out_overflow_reg <= ovf_reg;
         end
      end
   end

   assign out_val      = out_val_reg;
   assign out_valid    = out_valid_reg;
   assign out_overflow = out_overflow_reg;
   assign busy         = frame_open_reg | s1_valid_reg | s2_valid_reg | s3_valid_reg | s4_valid_reg;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 2-lane/40-bit instance and a 1-lane/33-bit instance share stimulus
// (the narrow one sees lane 0); results are scored against an integer frame model.
module tb_mac_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_first, in_last, signed_mode, sat_en;
   logic [31:0] in_a, in_b;
   logic [39:0] out_val0;
   logic [32:0] out_val1;
   logic        out_valid0, out_overflow0, busy0;
   logic        out_valid1, out_overflow1, busy1;

   always #5 clk = ~clk;

   mac_accum #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(40), .LANES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode), .sat_en(sat_en),
      .out_val(out_val0), .out_valid(out_valid0), .out_overflow(out_overflow0), .busy(busy0));

   mac_accum #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(33), .LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a[15:0]), .in_b(in_b[15:0]),
      .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode), .sat_en(sat_en),
      .out_val(out_val1), .out_valid(out_valid1), .out_overflow(out_overflow1), .busy(busy1));

   typedef struct {
      logic [63:0] val;
      bit          ovf;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [15:0] a0, a1, b0, b1;
      bit          sm;
      logic [39:0] exp_val;
      bit          exp_ovf;
   } vec_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [63:0] last_val[2];
   bit          last_ovf[2];

   // Frame model state, per instance
   longint      m_acc[2];
   bit          m_ovf[2], m_open[2], m_sm[2], m_sat[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_rst();
      chk("reset0", {22'b0, out_val0, out_valid0, out_overflow0, busy0}, 64'd0);
      chk("reset1", {29'b0, out_val1, out_valid1, out_overflow1, busy1}, 64'd0);
      last_val[0] = '0; last_val[1] = '0;
      last_ovf[0] = 1'b0; last_ovf[1] = 1'b0;
   endtask

   task automatic mon(input int i, input logic v, input logic [63:0] val, input logic ovf);
      exp_t e;
      bit   have;
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (i == 0) ? q0[0] : q1[0];
      if (v) begin
         n_cmp++;
         if (!have) begin
            n_fail++;
            $display("FAIL out%0d unexpected: got val=%h ovf=%0d at cycle %0d, expected no result", i, val, ovf, cyc);
         end else begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            if (e.cyc != cyc || e.val !== val || e.ovf !== ovf) begin
               n_fail++;
               $display("FAIL out%0d result: got val=%h ovf=%0d cyc=%0d expected val=%h ovf=%0d cyc=%0d",
                        i, val, ovf, cyc, e.val, e.ovf, e.cyc);
            end
         end
         last_val[i] = val;
         last_ovf[i] = ovf;
      end else begin
         if (have && e.cyc <= cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out%0d missing: got no out_valid at cycle %0d expected val=%h", i, cyc, e.val);
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         chk($sformatf("hold%0d", i), {val, 63'(ovf)}, {last_val[i], 63'(last_ovf[i])});
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst_n) begin
         check_rst();
      end else begin
         mon(0, out_valid0, {24'b0, out_val0}, out_overflow0);
         mon(1, out_valid1, {31'b0, out_val1}, out_overflow1);
      end
   endtask

   // Integer model: products as signed/unsigned numbers, range check for overflow.
   task automatic model_beat(input logic [31:0] a, input logic [31:0] b,
                             input bit f, input bit l, input bit sm, input bit sat);
      for (int i = 0; i < 2; i++) begin
         int     lanes, ow;
         longint s, nv, lo, hi, span, x, y;
         bit     first;
         exp_t   e;
         lanes = (i == 0) ? 2 : 1;
         ow    = (i == 0) ? 40 : 33;
         first = f || !m_open[i];
         if (first) begin
            m_sm[i]  = sm;
            m_sat[i] = sat;
         end
         s = 0;
         for (int k = 0; k < lanes; k++) begin
            x = m_sm[i] ? longint'($signed(a[k*16 +: 16])) : longint'(a[k*16 +: 16]);
            y = m_sm[i] ? longint'($signed(b[k*16 +: 16])) : longint'(b[k*16 +: 16]);
            s += x * y;
         end
         span = longint'(1) << ow;
         if (m_sm[i]) begin lo = -(span / 2); hi = span / 2 - 1; end
         else         begin lo = 0;           hi = span - 1;     end
         nv = first ? s : m_acc[i] + s;
         if (first) m_ovf[i] = 1'b0;
         if (nv > hi || nv < lo) begin
            m_ovf[i] = 1'b1;
            if (m_sat[i]) nv = (nv > hi) ? hi : lo;
            else begin
               nv = nv & (span - 1);
               if (m_sm[i] && nv > hi) nv -= span;
            end
         end
         m_acc[i]  = nv;
         m_open[i] = !l;
         if (l) begin
            e.val = 64'(nv & (span - 1));
            e.ovf = m_ovf[i];
            e.cyc = cyc + 5;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
         end
      end
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] b,
                       input bit f, input bit l, input bit sm, input bit sat);
      in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
      signed_mode = sm; sat_en = sat;
      model_beat(a, b, f, l, sm, sat);
      tick();
   endtask

   task automatic bubble();
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
      in_first = 1'($urandom); in_last = 1'($urandom);
      signed_mode = 1'($urandom); sat_en = 1'($urandom);
      tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
         bubble();
         n++;
      end
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d results pending after 40 cycles expected 0/0", q0.size(), q1.size());
         q0.delete(); q1.delete();
      end
      bubble(); bubble();
      chk("idle_busy", {62'b0, busy0, busy1}, 64'd0);
   endtask

   function automatic logic [15:0] rnd_op();
      logic [15:0] pick [4];
      pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;
      if ($urandom_range(0, 1) == 0) return pick[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   task automatic run_random(input int frames);
      int len;
      bit sm, sat, skip_first, f;
      for (int fr = 0; fr < frames; fr++) begin
         len        = $urandom_range(1, 4);
         sm         = 1'($urandom);
         sat        = 1'($urandom);
         skip_first = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            f = (j == 0) ? !skip_first : ($urandom_range(0, 9) == 0);
            beat({rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, f, j == len - 1,
                 (j == 0) ? sm : 1'($urandom), (j == 0) ? sat : 1'($urandom));
         end
      end
      drain();
   endtask

   vec_t vec[8];

   initial begin
      vec[0] = '{16'd3,    16'd4,    16'd5,    16'd6,    1'b0, 40'd39,           1'b0};
      vec[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 40'h01FFFC0002,   1'b0};
      vec[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 40'd2,            1'b0};
      vec[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 40'h0080000000,   1'b0};
      vec[4] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 40'hFFFFFF8001,   1'b0};
      vec[5] = '{16'h8000, 16'd0,    16'd2,    16'd0,    1'b0, 40'h0000010000,   1'b0};
      vec[6] = '{16'd2,    16'd0,    16'hFFFD, 16'd0,    1'b1, 40'hFFFFFFFFFA,   1'b0};
      vec[7] = '{16'd2,    16'd0,    16'hFFFD, 16'd0,    1'b0, 40'h000001FFFA,   1'b0};

      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 0; m_ovf[i] = 0; m_open[i] = 0; m_sm[i] = 0; m_sat[i] = 0;
      end
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_first = 1'b0; in_last = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      bubble(); bubble();

      // Single-beat frames with fixed expectations
      for (int i = 0; i < 8; i++) begin
         beat({vec[i].a1, vec[i].a0}, {vec[i].b1, vec[i].b0}, 1'b1, 1'b1, vec[i].sm, 1'b0);
         drain();
         chk($sformatf("vec%0d_val", i), last_val[0], 64'(vec[i].exp_val));
         chk($sformatf("vec%0d_ovf", i), 64'(last_ovf[0]), 64'(vec[i].exp_ovf));
      end

      // Signed frame with a bubble: -13, -100, +25
      beat({16'd1, 16'hFFFE}, {16'd1, 16'd7}, 1'b1, 1'b0, 1'b1, 1'b0);
      bubble();
      beat({16'd0, 16'd100}, {16'd0, 16'hFFFF}, 1'b0, 1'b0, 1'b0, 1'b1);
      beat({16'd0, 16'd5},   {16'd0, 16'd5},    1'b0, 1'b1, 1'b0, 1'b1);
      drain();
      chk("signed_frame_val", last_val[0], 64'hFF_FFFF_FFA8);
      chk("signed_frame_ovf", 64'(last_ovf[0]), 64'd0);

      // Three beats of 0xFFFF*0xFFFF into the 33-bit single-lane instance
      for (int s = 1; s >= 0; s--) begin
         beat({16'd0, 16'hFFFF}, {16'd0, 16'hFFFF}, 1'b1, 1'b0, 1'b0, 1'(s));
         beat({16'd0, 16'hFFFF}, {16'd0, 16'hFFFF}, 1'b0, 1'b0, 1'b0, 1'(s));
         beat({16'd0, 16'hFFFF}, {16'd0, 16'hFFFF}, 1'b0, 1'b1, 1'b0, 1'(s));
         drain();
         chk($sformatf("ovf33_sat%0d_val", s), last_val[1], (s == 1) ? 64'h1_FFFF_FFFF : 64'h0_FFFA_0003);
         chk($sformatf("ovf33_sat%0d_ovf", s), 64'(last_ovf[1]), 64'd1);
      end

      // Reset in the middle of a frame; nothing may come out of it
      beat({16'd0, 16'd9}, {16'd0, 16'd9}, 1'b1, 1'b0, 1'b0, 1'b0);
      beat({16'd1, 16'd2}, {16'd3, 16'd4}, 1'b0, 1'b0, 1'b0, 1'b0);
      bubble();
      #2 rst_n = 1'b0;
      #1 check_rst();
      m_open[0] = 1'b0; m_open[1] = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (8) bubble();
      beat({16'd0, 16'd2}, {16'd0, 16'd3}, 1'b1, 1'b1, 1'b0, 1'b0);
      drain();
      chk("after_reset_val", last_val[0], 64'd6);

      // Back-to-back single-beat frames
      beat({16'd0, 16'd1}, {16'd0, 16'd1}, 1'b1, 1'b1, 1'b0, 1'b0);
      beat({16'd0, 16'd2}, {16'd0, 16'd2}, 1'b1, 1'b1, 1'b0, 1'b0);
      drain();
      chk("b2b_last_val", last_val[0], 64'd4);

      // in_first reasserted mid-frame abandons the open frame
      beat({16'd0, 16'd10}, {16'd0, 16'd10}, 1'b1, 1'b0, 1'b0, 1'b0);
      beat({16'd0, 16'd20}, {16'd0, 16'd20}, 1'b0, 1'b0, 1'b0, 1'b0);
      beat({16'd0, 16'd3},  {16'd0, 16'd3},  1'b1, 1'b0, 1'b0, 1'b0);
      beat({16'd0, 16'd4},  {16'd0, 16'd4},  1'b0, 1'b1, 1'b0, 1'b0);
      drain();
      chk("restart_val", last_val[0], 64'd25);

      run_random(150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
